// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared constants for the instruction-decode stage.
//   - control vector bit indices and CONTROL_REG_SIZE
//   - primary opcode values used for classification
//   - helper functions: control-vector decode and operand-use predicates
package decode_stage_pkg;

  localparam int DATA_W           = 32;
  localparam int CONTROL_REG_SIZE = 7;

  // Control vector bit indices
  localparam int R_TYPE    = 0;
  localparam int I_TYPE    = 1;
  localparam int J_TYPE    = 2;
  localparam int MEM_READ  = 3;
  localparam int MEM_WRITE = 4;
  localparam int REG_WRITE = 5;
  localparam int DEST_RT   = 6;

  // Primary opcodes (insn[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  typedef logic [CONTROL_REG_SIZE-1:0] ctrl_t;

  // Unknown opcodes fall through to an all-zero vector.
  function automatic ctrl_t decode_control(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_SPECIAL: begin
        c[R_TYPE]    = 1'b1;
        c[REG_WRITE] = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_LUI, OP_ORI: begin
        c[I_TYPE]    = 1'b1;
        c[REG_WRITE] = 1'b1;
        c[DEST_RT]   = 1'b1;
      end
      OP_LW: begin
        c[I_TYPE]    = 1'b1;
        c[MEM_READ]  = 1'b1;
        c[REG_WRITE] = 1'b1;
        c[DEST_RT]   = 1'b1;
      end
      OP_SW: begin
        c[I_TYPE]    = 1'b1;
        c[MEM_WRITE] = 1'b1;
      end
      OP_J, OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_REGIMM: begin
        c[J_TYPE]    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return (op != OP_J);
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_SPECIAL) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile: 32 x 32 register file for the decode stage.
//   Two combinational read ports, one synchronous write port, async
//   active-low clear. r0 always reads zero and ignores writes.
//   Optional macro DECODE_WB_BYPASS_EN forwards same-cycle write data
//   onto the read ports.
// Ports:
//   clock, reset_n       clock / async active-low clear
//   we, waddr, wdata     write port (rising edge)
//   raddr_a, raddr_b     read addresses
//   rdata_a, rdata_b     combinational read data
module decode_stage_regfile
  import decode_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
`ifdef DECODE_WB_BYPASS_EN
    // Forward the value being written this edge so the consumer sees it now.
    if (we && (waddr != 5'd0) && (waddr == raddr_a)) rdata_a = wdata;
    if (we && (waddr != 5'd0) && (waddr == raddr_b)) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode pipeline stage feeding the execute ALU.
//   Reads rs/rt from the register file, builds the control vector and
//   registers everything into the ID/EX register. Detects load-use
//   hazards (stall), squashes on a taken branch (flush), and accepts the
//   write-back port. Optional macro DECODE_WB_BYPASS_EN (in the regfile)
//   forwards same-cycle write-back data into the operands.
// Ports:
//   clock, reset_n           clock / async active-low reset
//   insn_in, pc_in           fetched instruction and its PC
//   insn_valid               insn_in/pc_in valid this cycle
//   stall                    combinational; fetch holds input while high
//   flush                    branch taken; squash this stage
//   wb_we, wb_addr, wb_data  register-file write-back port
//   rsData, rtData           registered operands
//   control                  registered control vector
//   insn_out, pc_out         registered instruction and PC
//   valid_out                output register holds a real instruction
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [31:0]                 insn_in,
  input  logic [31:0]                 pc_in,
  input  logic                        insn_valid,
  output logic                        stall,
  input  logic                        flush,
  input  logic                        wb_we,
  input  logic [4:0]                  wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  output logic [DATA_W-1:0]           rsData,
  output logic [DATA_W-1:0]           rtData,
  output logic [CONTROL_REG_SIZE-1:0] control,
  output logic [31:0]                 insn_out,
  output logic [31:0]                 pc_out,
  output logic                        valid_out
);

  logic [5:0]        op_p0;
  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic [4:0]        rt_p1;
  logic [DATA_W-1:0] rs_val_p0;
  logic [DATA_W-1:0] rt_val_p0;
  ctrl_t             ctrl_p0;
  logic              hazard_p0;
  logic              load_p0;

  assign op_p0   = insn_in[31:26];
  assign rs_p0   = insn_in[25:21];
  assign rt_p0   = insn_in[20:16];
  assign rt_p1   = insn_out[20:16];
  assign ctrl_p0 = decode_control(op_p0);

  decode_stage_regfile u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_p0),
    .raddr_b (rt_p0),
    .rdata_a (rs_val_p0),
    .rdata_b (rt_val_p0)
  );

  // Load in ID/EX whose destination (rt) is consumed by the incoming insn.
  always_comb begin
    hazard_p0 = valid_out && control[MEM_READ] && (rt_p1 != 5'd0) && insn_valid &&
                ((uses_rs(op_p0) && (rs_p0 == rt_p1)) ||
                 (uses_rt(op_p0) && (rt_p0 == rt_p1)));
  end

  // A taken branch discards the input, so fetch must not be told to hold it.
  assign stall   = hazard_p0 && !flush;
  assign load_p0 = insn_valid && !flush && !hazard_p0;

  // ---- ID/EX register boundary (p0 -> p1) ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsData    <= '0;
      rtData    <= '0;
      control   <= '0;
      insn_out  <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (load_p0) begin
      rsData    <= rs_val_p0;
      rtData    <= rt_val_p0;
      control   <= ctrl_p0;
      insn_out  <= insn_in;
      pc_out    <= pc_in;
      valid_out <= 1'b1;
    end else begin
      rsData    <= '0;
      rtData    <= '0;
      control   <= '0;
      insn_out  <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end
  end

endmodule
